// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter.
// Provides:
//   - default bit timing (BAUD_CNT, HALF_CNT)
//   - payload width (DATA_BITS)
//   - the receiver state enum
package uart_pkg;

  localparam int BAUD_CNT  = 2604;
  localparam int HALF_CNT  = 1302;
  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA
  } rx_state_t;

endpackage

// File: rtl/uart_rcv_if.sv
// Receiver-side UART bundle: the serial line, the consumer handshake and the
// error pulses.
//   slave  : the receiver (takes RX/clr_rdy, drives data and flags)
//   master : whoever feeds the line and consumes bytes
interface uart_rcv_if;
  import uart_pkg::*;

  logic                 RX;
  logic                 clr_rdy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rdy;
  logic                 frm_err;
  logic                 ovr_err;

  modport slave (
    input  RX, clr_rdy,
    output rx_data, rdy, frm_err, ovr_err
  );

  modport master (
    output RX, clr_rdy,
    input  rx_data, rdy, frm_err, ovr_err
  );

endinterface

// File: rtl/uart_rcv_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops take RESET_VAL during reset, so an idle-high line does not look
// like an edge when reset is released.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output, two clk behind d
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Plain two-stage shift; the first stage may go metastable, the second is
  // the one the rest of the design is allowed to look at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rcv.sv
// UART 8N1 receiver: one start bit, eight data bits LSB first, one stop bit.
// Each bit is sampled at mid-bit. The byte is then presented with a rdy/clr_rdy
// level handshake. Framing and overrun errors are flagged as one-clk pulses.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_rcv_if.slave
//                (RX, clr_rdy in; rx_data, rdy, frm_err, ovr_err out)
module uart_rcv #(
  parameter int BAUD_CNT = uart_pkg::BAUD_CNT,
  parameter int HALF_CNT = uart_pkg::HALF_CNT
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_rcv_if.slave  bus
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(BAUD_CNT + 1);

  rx_state_t            state_q, state_d;
  logic                 rx_s;
  logic [CNT_W-1:0]     baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rdy_q, frm_err_q, ovr_err_q;

  logic sample, stop_sample;
  logic start_det, data_shift, frame_ok, frame_bad;

  sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.RX),
    .q     (rx_s)
  );

  // The baud counter reaches 1 on the clk before each mid-bit point, so the
  // sample edge lands exactly HALF_CNT / BAUD_CNT clk after the load.
  assign sample      = (state_q != IDLE) && (baud_cnt == CNT_W'(1));
  assign stop_sample = (state_q == DATA) && sample && (bit_cnt == 4'(DATA_BITS));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s)       state_d = START;
      START:   if (sample)      state_d = rx_s ? IDLE : DATA;
      DATA:    if (stop_sample) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // FSM control strobes for the datapath below.
  always_comb begin
    start_det  = 1'b0;
    data_shift = 1'b0;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    case (state_q)
      IDLE: start_det = !rx_s;
      DATA: begin
        data_shift = sample && !stop_sample;
        frame_ok   = stop_sample && rx_s;
        frame_bad  = stop_sample && !rx_s;
      end
      default: ;
    endcase
  end

  // Bit timing and bit capture.
  // The stop bit is judged straight from rx_s, so only the data bits are
  // stored. Bits enter at the MSB end, which leaves the byte in order
  // after eight shifts. bit_cnt counts every DATA sample (stop included).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
    end else begin
      if (start_det) begin
        baud_cnt <= CNT_W'(HALF_CNT);
        bit_cnt  <= '0;
      end else if (state_q != IDLE) begin
        baud_cnt <= sample ? CNT_W'(BAUD_CNT) : baud_cnt - 1'b1;
        if (state_q == DATA && sample) bit_cnt <= bit_cnt + 1'b1;
      end
      if (data_shift) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
    end
  end

  // Consumer-facing outputs.
  // When a completed byte and clr_rdy land on the same clk, the new byte
  // wins: rdy stays set and no overrun is reported, because the consumer
  // has just taken the old byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q <= '0;
      rdy_q     <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      frm_err_q <= frame_bad;
      ovr_err_q <= frame_ok && rdy_q && !bus.clr_rdy;
      if (frame_ok) begin
        rx_data_q <= shift_q;
        rdy_q     <= 1'b1;
      end else if (bus.clr_rdy) begin
        rdy_q     <= 1'b0;
      end
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_err_q;
  assign bus.ovr_err = ovr_err_q;

endmodule

// File: tb/tb_uart_rcv.sv
// Directed testbench for uart_rcv.
// The bit period is scaled down (BAUD 260 / HALF 130, same 2:1 ratio) to keep
// the run short. All timing expectations are derived from those two numbers.
// A monitor turns each DUT output event into a scoreboard lookup:
//   rdy rise, frm_err pulse, ovr_err pulse.
// Expected events are queued by the stimulus ahead of each frame.
module tb_uart_rcv;
  import uart_pkg::*;

  localparam int TB_BAUD = 260;
  localparam int TB_HALF = 130;
  localparam int B_FAST  = TB_BAUD - TB_BAUD / 50;
  localparam int B_SLOW  = TB_BAUD + TB_BAUD / 50;
  // Clk from the launch of the start bit to rdy being seen high:
  // one edge to catch RX, two sync flops, then HALF + 9 bit periods.
  localparam int EXP_LAT = 3 + TB_HALF + 9 * TB_BAUD;

  localparam int EV_RDY = 0;
  localparam int EV_FRM = 1;
  localparam int EV_OVR = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  int   start_cyc;
  int   rise_cyc;
  logic rdy_prev;
  ev_t  exp_q[$];

  uart_rcv_if bus ();

  uart_rcv #(
    .BAUD_CNT (TB_BAUD),
    .HALF_CNT (TB_HALF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpect(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic handleEvent(input int kind, input logic [7:0] data);
    ev_t e;
    checkOutput("sb_pending", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("sb_kind", 32'(kind), 32'(e.kind));
      checkOutput("sb_data", 32'(data), 32'(e.data));
    end
  endtask

  // Called at posedge+1; returns at posedge+1 at the end of the stop bit.
  // A low stop bit is held just past mid-bit and then released, so the tail
  // is rejected as a false start instead of racing the receiver.
  task automatic applyStimulus(input logic [7:0] b, input int bit_clks, input logic stop_val);
    bus.RX    = 1'b0;
    start_cyc = cyc;
    repeat (bit_clks) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      repeat (bit_clks) @(posedge clk);
      #1;
    end
    if (stop_val) begin
      bus.RX = 1'b1;
      repeat (bit_clks) @(posedge clk);
      #1;
    end else begin
      bus.RX = 1'b0;
      repeat (bit_clks / 2 + 20) @(posedge clk);
      #1;
      bus.RX = 1'b1;
      repeat (bit_clks) @(posedge clk);
      #1;
    end
  endtask

  task automatic idleFor(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseClr();
    bus.clr_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_rdy = 1'b0;
  endtask

  // Output monitor: each rdy rise, frm_err or ovr_err clk is one event.
  // A pulse wider than one clk therefore shows up as an unexpected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rdy && !rdy_prev) begin
        rise_cyc = cyc;
        handleEvent(EV_RDY, bus.rx_data);
      end
      if (bus.frm_err) handleEvent(EV_FRM, bus.rx_data);
      if (bus.ovr_err) handleEvent(EV_OVR, bus.rx_data);
    end
    rdy_prev = bus.rdy;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    bus.RX      = 1'b1;
    bus.clr_rdy = 1'b0;
    rdy_prev    = 1'b0;
    rise_cyc    = 0;
    start_cyc   = 0;

    #12;
    checkOutput("rst_rx_data", 32'(bus.rx_data), 32'h00);
    checkOutput("rst_rdy", 32'(bus.rdy), 32'd0);
    checkOutput("rst_frm", 32'(bus.frm_err), 32'd0);
    checkOutput("rst_ovr", 32'(bus.ovr_err), 32'd0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleFor(10);
    checkOutput("rel_state", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] test 1: frame 0xA5, latency, clr_rdy");
    pushExpect(EV_RDY, 8'hA5);
    applyStimulus(8'hA5, TB_BAUD, 1'b1);
    checkOutput("t1_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t1_lat_ok", 32'((rise_cyc - start_cyc >= EXP_LAT - 1) &&
                                (rise_cyc - start_cyc <= EXP_LAT + 1)), 32'd1);
    checkOutput("t1_rx_data", 32'(bus.rx_data), 32'hA5);
    checkOutput("t1_rdy", 32'(bus.rdy), 32'd1);
    pulseClr();
    checkOutput("t1_rdy_clr", 32'(bus.rdy), 32'd0);
    pulseClr();
    checkOutput("t1_clr_idle", 32'(bus.rdy), 32'd0);
    idleFor(TB_BAUD);

    $display("[TB] test 2: glitch then frame 0x3C");
    bus.RX = 1'b0;
    idleFor(50);
    bus.RX = 1'b1;
    idleFor(50);
    checkOutput("t2_in_start", 32'(dut.state_q), 32'(START));
    idleFor(40);
    checkOutput("t2_back_idle", 32'(dut.state_q), 32'(IDLE));
    checkOutput("t2_rdy", 32'(bus.rdy), 32'd0);
    idleFor(TB_BAUD);
    pushExpect(EV_RDY, 8'h3C);
    applyStimulus(8'h3C, TB_BAUD, 1'b1);
    checkOutput("t2_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t2_rx_data", 32'(bus.rx_data), 32'h3C);
    pulseClr();
    idleFor(TB_BAUD);

    $display("[TB] test 3: frame 0x81 with bad stop");
    pushExpect(EV_FRM, 8'h3C);
    applyStimulus(8'h81, TB_BAUD, 1'b0);
    idleFor(TB_BAUD);
    checkOutput("t3_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t3_rdy", 32'(bus.rdy), 32'd0);
    checkOutput("t3_rx_data", 32'(bus.rx_data), 32'h3C);
    checkOutput("t3_state", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] test 4: back-to-back 0x11, 0x22");
    pushExpect(EV_RDY, 8'h11);
    pushExpect(EV_OVR, 8'h22);
    applyStimulus(8'h11, TB_BAUD, 1'b1);
    applyStimulus(8'h22, TB_BAUD, 1'b1);
    checkOutput("t4_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t4_rx_data", 32'(bus.rx_data), 32'h22);
    checkOutput("t4_rdy", 32'(bus.rdy), 32'd1);
    pulseClr();
    idleFor(TB_BAUD);

    $display("[TB] test 5: clr_rdy on the stop-sample clk");
    pushExpect(EV_RDY, 8'h77);
    applyStimulus(8'h77, TB_BAUD, 1'b1);
    idleFor(TB_BAUD);
    checkOutput("t5_pre_rdy", 32'(bus.rdy), 32'd1);
    fork
      applyStimulus(8'h5A, TB_BAUD, 1'b1);
      begin
        repeat (EXP_LAT - 1) @(posedge clk);
        #1;
        bus.clr_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_rdy = 1'b0;
        checkOutput("t5_rdy_kept", 32'(bus.rdy), 32'd1);
        checkOutput("t5_ovr", 32'(bus.ovr_err), 32'd0);
      end
    join
    checkOutput("t5_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t5_rx_data", 32'(bus.rx_data), 32'h5A);
    checkOutput("t5_rdy", 32'(bus.rdy), 32'd1);
    idleFor(TB_BAUD);

    $display("[TB] test 6: reset mid-frame, then +/-2%% baud");
    fork
      applyStimulus(8'hF0, TB_BAUD, 1'b1);
      begin
        repeat (4 * TB_BAUD) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rx_data", 32'(bus.rx_data), 32'h00);
        checkOutput("t6_rdy", 32'(bus.rdy), 32'd0);
        checkOutput("t6_frm", 32'(bus.frm_err), 32'd0);
        checkOutput("t6_ovr", 32'(bus.ovr_err), 32'd0);
        checkOutput("t6_state", 32'(dut.state_q), 32'(IDLE));
      end
    join
    idleFor(5);
    rst_n = 1'b1;
    idleFor(TB_BAUD);
    checkOutput("t6_no_garbage", 32'(bus.rdy), 32'd0);
    pushExpect(EV_RDY, 8'hFF);
    applyStimulus(8'hFF, B_FAST, 1'b1);
    checkOutput("t6_fast_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t6_fast_data", 32'(bus.rx_data), 32'hFF);
    pulseClr();
    idleFor(TB_BAUD);
    pushExpect(EV_RDY, 8'h00);
    applyStimulus(8'h00, B_SLOW, 1'b1);
    checkOutput("t6_slow_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t6_slow_data", 32'(bus.rx_data), 32'h00);
    checkOutput("t6_slow_rdy", 32'(bus.rdy), 32'd1);
    idleFor(TB_BAUD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
